apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_if.sv | 37 +++
 rtl/apb_cmd_master.sv | 119 +++++++++++
 tb/tb_apb_cmd_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB requester bus for apb_cmd_master.
// master modport is the bridge's view; slave modport is the command source / APB completer side.
interface apb_cmd_master_if #(
  parameter int APB_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [APB_WIDTH-1:0]  CMD_WDATA;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [APB_WIDTH-1:0]  RSP_RDATA;
  logic                  RSP_ERR;
  logic                  RSP_TIMEOUT;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [APB_WIDTH-1:0]  PWDATA;
  logic [APB_WIDTH-1:0]  PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB requester: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered.
// Define APB_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT_CYCLES.
module apb_cmd_master #(
  parameter int APB_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               SYSCLK_apb,
  input  logic               PRESETN,
  apb_cmd_master_if.master   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
    $error("apb_cmd_master: TIMEOUT_CYCLES out of range");
  if (APB_WIDTH != 8 && APB_WIDTH != 16 && APB_WIDTH != 32)
    $error("apb_cmd_master: APB_WIDTH must be 8, 16 or 32");

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [APB_WIDTH-1:0]  wdata;
  } req_t;

  typedef struct packed {
    logic [APB_WIDTH-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } rsp_t;

  logic [1:0] state;
  req_t       req;
  rsp_t       rsp;
  logic       psel, penable, cmd_ready, rsp_valid;

`ifdef APB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;
  // to_cnt holds the number of completed PREADY=0 cycles, so the current one is the last allowed
  assign to_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= IDLE;
      req       <= '0;
      rsp       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && bus.CMD_VALID) begin
            req       <= '{write: bus.CMD_WRITE, addr: bus.CMD_ADDR, wdata: bus.CMD_WDATA};
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp     <= '{rdata: (req.write ? '0 : bus.PRDATA), err: bus.PSLVERR, timeout: 1'b0};
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_hit) begin
            rsp     <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
          end else begin
            to_cnt  <= to_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          // first RESP cycle is the register stage that raises RSP_VALID
          if (rsp_valid && bus.RSP_READY) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY   = cmd_ready;
  assign bus.RSP_VALID   = rsp_valid;
  assign bus.RSP_RDATA   = rsp.rdata;
  assign bus.RSP_ERR     = rsp.err;
  assign bus.RSP_TIMEOUT = rsp.timeout;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = req.write;
  assign bus.PADDR       = req.addr;
  assign bus.PWDATA      = req.wdata;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: writes, wait-state reads, errors, back-to-back, timeout/stall, reset abort.
module tb_apb_cmd_master;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_cmd_master_if #(.APB_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  apb_cmd_master #(.APB_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .SYSCLK_apb (clk),
    .PRESETN    (rstn),
    .bus        (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = w;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
  endtask

  task automatic handoff(input string tag);
    bus.RSP_READY = 1'b1;
    tick();
    chk({tag, "_hand_vld"}, bus.RSP_VALID, 0);
    chk({tag, "_hand_rdy"}, bus.CMD_READY, 1);
    bus.RSP_READY = 1'b0;
  endtask

  initial begin
    bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0;
    bus.RSP_READY = 0; bus.PRDATA = 0; bus.PREADY = 0; bus.PSLVERR = 0;

    // reset state
    tick(2);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_pen", bus.PENABLE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_cmdrdy", bus.CMD_READY, 0);
    chk("rst_rspvld", bus.RSP_VALID, 0);
    chk("rst_rdata", bus.RSP_RDATA, 0);
    chk("rst_to", bus.RSP_TIMEOUT, 0);
    rstn = 1'b1;
    chk("rel_cmdrdy_pre", bus.CMD_READY, 0);
    tick();
    chk("rel_cmdrdy", bus.CMD_READY, 1);

    // write 0xA5 -> 0x01, zero wait states
    cmd(1'b1, 8'h01, 32'h0000_00A5);
    bus.PREADY = 1'b1;
    tick();
    bus.CMD_VALID = 1'b0;
    chk("wr_setup_psel", bus.PSEL, 1);
    chk("wr_setup_pen", bus.PENABLE, 0);
    chk("wr_paddr", bus.PADDR, 32'h01);
    chk("wr_pwdata", bus.PWDATA, 32'hA5);
    chk("wr_pwrite", bus.PWRITE, 1);
    chk("wr_cmdrdy", bus.CMD_READY, 0);
    tick();
    chk("wr_acc_psel", bus.PSEL, 1);
    chk("wr_acc_pen", bus.PENABLE, 1);
    tick();
    chk("wr_done_psel", bus.PSEL, 0);
    chk("wr_e2_vld", bus.RSP_VALID, 0);
    tick();
    chk("wr_e3_vld", bus.RSP_VALID, 1);
    chk("wr_err", bus.RSP_ERR, 0);
    chk("wr_rdata", bus.RSP_RDATA, 0);
    handoff("wr");

    // read 0x00 with 3 wait states; PSLVERR/PRDATA ignored while PREADY=0
    cmd(1'b0, 8'h00, 32'hFFFF_FFFF);
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hDEAD_BEEF;
    tick();
    bus.CMD_VALID = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rdw_psel", bus.PSEL, 1);
      chk("rdw_pen", bus.PENABLE, 1);
      chk("rdw_paddr", bus.PADDR, 0);
      tick();
    end
    chk("rdw_last_pen", bus.PENABLE, 1);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h1234_5678;
    tick();
    bus.PREADY = 1'b0; bus.PRDATA = 32'h0;
    chk("rdw_exit_psel", bus.PSEL, 0);
    tick();
    chk("rdw_vld", bus.RSP_VALID, 1);
    chk("rdw_rdata", bus.RSP_RDATA, 32'h1234_5678);
    chk("rdw_err", bus.RSP_ERR, 0);
    handoff("rdw");

    // read 0x02 with PSLVERR, response stalled while a new command waits
    cmd(1'b0, 8'h02, 32'h0);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hCAFE_0002;
    tick();
    cmd(1'b1, 8'h33, 32'h3333);
    tick(3);
    bus.PSLVERR = 1'b0; bus.PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("err_vld", bus.RSP_VALID, 1);
      chk("err_err", bus.RSP_ERR, 1);
      chk("err_to", bus.RSP_TIMEOUT, 0);
      chk("err_rdata", bus.RSP_RDATA, 32'hCAFE_0002);
      chk("err_nopsel", bus.PSEL, 0);
      tick();
    end
    bus.CMD_VALID = 1'b0;
    handoff("err");
    chk("err_after_psel", bus.PSEL, 0);

    // back-to-back with RSP_READY held high
    bus.RSP_READY = 1'b1; bus.PREADY = 1'b1;
    cmd(1'b1, 8'h03, 32'h11);
    tick();
    cmd(1'b1, 8'h04, 32'h22);
    tick(3);
    chk("b2b_v_vld", bus.RSP_VALID, 1);
    chk("b2b_v_psel", bus.PSEL, 0);
    tick();
    chk("b2b_h_vld", bus.RSP_VALID, 0);
    chk("b2b_h_psel", bus.PSEL, 0);
    tick();
    bus.CMD_VALID = 1'b0;
    chk("b2b_setup_psel", bus.PSEL, 1);
    chk("b2b_setup_pen", bus.PENABLE, 0);
    chk("b2b_paddr", bus.PADDR, 32'h04);
    chk("b2b_pwdata", bus.PWDATA, 32'h22);
    tick(3);
    chk("b2b_2_vld", bus.RSP_VALID, 1);
    chk("b2b_2_rdata", bus.RSP_RDATA, 0);
    tick();
    chk("b2b_2_done", bus.RSP_VALID, 0);
    bus.RSP_READY = 1'b0;

    // PREADY stuck low
    bus.PREADY = 1'b0; bus.PRDATA = 32'h5555_AAAA;
    cmd(1'b0, 8'h05, 32'h0);
    tick();
    bus.CMD_VALID = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_psel", bus.PSEL, 1);
      chk("to_pen", bus.PENABLE, 1);
      tick();
    end
    chk("to_exit_psel", bus.PSEL, 0);
    chk("to_exit_vld", bus.RSP_VALID, 0);
    tick();
    chk("to_vld", bus.RSP_VALID, 1);
    chk("to_err", bus.RSP_ERR, 1);
    chk("to_to", bus.RSP_TIMEOUT, 1);
    chk("to_rdata", bus.RSP_RDATA, 0);
    handoff("to");
    // PREADY on the terminal cycle completes normally
    cmd(1'b0, 8'h06, 32'h0);
    tick();
    bus.CMD_VALID = 1'b0;
    tick(4);
    chk("tw_psel", bus.PSEL, 1);
    bus.PREADY = 1'b1; bus.PRDATA = 32'h77;
    tick();
    bus.PREADY = 1'b0;
    tick();
    chk("tw_vld", bus.RSP_VALID, 1);
    chk("tw_err", bus.RSP_ERR, 0);
    chk("tw_to", bus.RSP_TIMEOUT, 0);
    chk("tw_rdata", bus.RSP_RDATA, 32'h77);
    handoff("tw");
`else
    tick(1000);
    chk("stall_psel", bus.PSEL, 1);
    chk("stall_pen", bus.PENABLE, 1);
    chk("stall_vld", bus.RSP_VALID, 0);
    chk("stall_to", bus.RSP_TIMEOUT, 0);
    rstn = 1'b0;
    #1;
    chk("stall_rst_psel", bus.PSEL, 0);
    tick();
    rstn = 1'b1;
    tick();
`endif

    // reset during ACCESS of a write
    cmd(1'b1, 8'h07, 32'h99);
    bus.PREADY = 1'b0;
    tick();
    bus.CMD_VALID = 1'b0;
    tick(2);
    chk("ra_acc_pen", bus.PENABLE, 1);
    rstn = 1'b0;
    #1;
    chk("ra_psel", bus.PSEL, 0);
    chk("ra_pen", bus.PENABLE, 0);
    chk("ra_pwdata", bus.PWDATA, 0);
    chk("ra_vld", bus.RSP_VALID, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("ra_cmdrdy", bus.CMD_READY, 1);
    tick(3);
    chk("ra_novld", bus.RSP_VALID, 0);
    cmd(1'b0, 8'h08, 32'h0);
    bus.PREADY = 1'b1; bus.PRDATA = 32'hA0A0_A0A0;
    tick();
    bus.CMD_VALID = 1'b0;
    chk("ra_new_paddr", bus.PADDR, 32'h08);
    tick(3);
    chk("ra_new_vld", bus.RSP_VALID, 1);
    chk("ra_new_rdata", bus.RSP_RDATA, 32'hA0A0_A0A0);
    chk("ra_new_err", bus.RSP_ERR, 0);
    handoff("ra");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
